// File: rtl/parity_pkg.sv
// Shared definitions for the serial parity generator/checker pair.
package parity_pkg;

    // Receive FSM encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_t;

    // Parity mode selectors, common to generator and checker
    localparam bit PARITY_EVEN = 1'b0;
    localparam bit PARITY_ODD  = 1'b1;

endpackage

// File: rtl/parity_accum.sv
// Frame accumulator: LSB-first shift register, running XOR of the
// accepted data bits and a count of bits collected so far.
module parity_accum #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic              w,
    output logic [DATA_W-1:0] word,
    output logic              xor_acc,
    output logic [CNT_W-1:0]  cnt
);

    localparam int IDX_W = $clog2(DATA_W);

    // Place each accepted bit at the current index and fold it into the parity
    always_ff @(posedge clk) begin
        if (reset) begin
            word    <= '0;
            xor_acc <= 1'b0;
            cnt     <= '0;
        end else if (clr) begin
            xor_acc <= 1'b0;
            cnt     <= '0;
        end else if (en) begin
            word[cnt[IDX_W-1:0]] <= w;
            xor_acc              <= xor_acc ^ w;
            cnt                  <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_parity_checker.sv
// Serial parity checker: reassembles DATA_W-bit frames (LSB first, then
// one parity bit), flags parity failures and counts bad frames.
module serial_parity_checker #(
    parameter int DATA_W     = 8,
    parameter bit PARITY_ODD = parity_pkg::PARITY_EVEN,
    parameter int ERRCNT_W   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                w,
    input  logic                w_valid,
    input  logic                flush,
    output logic [DATA_W-1:0]   data_out,
    output logic                data_valid,
    output logic                parity_err,
    output logic                busy,
    output logic [ERRCNT_W-1:0] err_cnt
);

    import parity_pkg::state_t;
    import parity_pkg::IDLE;
    import parity_pkg::DATA;
    import parity_pkg::PAR;

    localparam int                CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(DATA_W - 1);

    state_t              state_q;
    state_t              state_d;
    logic                acc_en;
    logic                acc_clr;
    logic                frame_done;
    logic                exp_par;
    logic [DATA_W-1:0]   word;
    logic                xor_acc;
    logic [CNT_W-1:0]    cnt;

    parity_accum #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_accum (
        .clk     (clk),
        .reset   (reset),
        .clr     (acc_clr),
        .en      (acc_en),
        .w       (w),
        .word    (word),
        .xor_acc (xor_acc),
        .cnt     (cnt)
    );

    assign exp_par = xor_acc ^ PARITY_ODD;
    assign busy    = (state_q != IDLE);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and accumulator control; flush overrides any bit in the same cycle
    always_comb begin
        state_d    = state_q;
        acc_en     = 1'b0;
        acc_clr    = 1'b0;
        frame_done = 1'b0;
        if (flush) begin
            state_d = IDLE;
            acc_clr = 1'b1;
        end else if (w_valid) begin
            case (state_q)
                IDLE: begin
                    acc_en  = 1'b1;
                    state_d = DATA;
                end
                DATA: begin
                    acc_en = 1'b1;
                    if (cnt == LAST_IDX) begin
                        state_d = PAR;
                    end
                end
                PAR: begin
                    frame_done = 1'b1;
                    acc_clr    = 1'b1;
                    state_d    = IDLE;
                end
                default: begin
                    acc_clr = 1'b1;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Frame result registers: one-cycle pulse, data word held between frames
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            data_valid <= frame_done;
            parity_err <= frame_done & (w != exp_par);
            if (frame_done) begin
                data_out <= word;
            end
        end
    end

    // Saturating count of failed frames, driven by the registered error pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt <= '0;
        end else if (parity_err && (err_cnt != {ERRCNT_W{1'b1}})) begin
            err_cnt <= err_cnt + ERRCNT_W'(1);
        end
    end

endmodule

// File: doc/serial_parity_checker.md
# serial_parity_checker

Receive-side companion to the serial parity generator. Consumes a serial bit stream framed as DATA_W data bits (LSB first) followed by one parity bit. Reassembles each data word, checks its parity and reports a per-frame error flag. Keeps a saturating count of bad frames for status readout.

## Interface
- DATA_W, default 8: data bits per frame; legal range 2..32.
- PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity.
- ERRCNT_W, default 8: width of the error counter.

Ports:
- clk  in  1  single clock; everything samples on the rising edge.
- reset  in  1  synchronous, active-high reset.
- w  in  1  serial data/parity bit.
- w_valid  in  1  qualifies w; a bit is consumed only in cycles where w_valid=1.
- flush  in  1  synchronous abort of the frame in progress.
- data_out  out  DATA_W  last completed data word; holds its value between frames.
- data_valid  out  1  one-cycle pulse marking a completed frame.
- parity_err  out  1  valid only with data_valid; 1 means the parity check failed.
- busy  out  1  high from the first accepted data bit until the frame completes.
- err_cnt  out  ERRCNT_W  number of failed frames; saturates at all-ones.

## Operation
- FSM states:
  - IDLE: bit_cnt=0, busy=0.
  - DATA: collecting data bits, busy=1.
  - PAR: waiting for the parity bit, busy=1.
- IDLE with w_valid=1: load w into shift bit 0, bit_cnt←1, go to DATA.
- DATA with w_valid=1: place w at index bit_cnt, bit_cnt++. When bit_cnt reaches DATA_W after the increment, go to PAR.
- PAR with w_valid=1: compute exp = ^shift ^ PARITY_ODD. Register data_out←shift, data_valid←1, parity_err←(w≠exp). Go to IDLE.
- w_valid=0 in any state: no state, counter or shift change. Gaps of any length are legal.
- Running XOR: accumulate it alongside the shift register. Do not recompute at the end.
- err_cnt: increments by 1 on each parity_err=1 pulse. Holds at 2^ERRCNT_W−1. Cleared only by reset.
- flush=1: go to IDLE, clear bit_cnt and the running XOR, no data_valid pulse. data_out and err_cnt are unchanged.
- flush and w_valid in the same cycle: flush wins and the bit is discarded. This also applies in PAR, where the frame is dropped and not counted.
- parity_err outside a data_valid pulse: 0.

## Timing
- Reset values: data_out=0, data_valid=0, parity_err=0, busy=0, err_cnt=0. FSM is IDLE with bit_cnt=0.
- Reset mid-frame: identical to flush, and it additionally clears all outputs.
- Latency: data_valid and parity_err rise in the cycle after the edge that samples the parity bit. Both are high for exactly 1 cycle.
- err_cnt reflects a failed frame one cycle after its parity_err pulse.
- busy: goes high in the cycle after the first data bit is accepted. Drops together with the data_valid rise.
- Back-to-back frames: a new data bit may arrive in the cycle right after the parity bit. Its frame proceeds with no bubble.
- Minimum frame duration is DATA_W+1 cycles.

## Structure
- Shared package parity_pkg holds:
  - the FSM state encoding (IDLE/DATA/PAR as a 2-bit enum);
  - the PARITY_EVEN/PARITY_ODD constants, which the generator side also uses.
- Sub-module parity_accum: shift register, running XOR and bit counter.
  - Inputs: clk, reset, clr, en, w.
  - Outputs: word, xor_acc, cnt.
- The top level contains the FSM, the output registers and the error counter.

## Test plan
- Even parity, LSB first, 8'hA5 then parity 0, w_valid held high → data_out=8'hA5, data_valid pulse, parity_err=0, err_cnt=0.
- Same frame with parity bit 1 → parity_err=1 with data_valid, err_cnt=1 one cycle later.
- 8'h3C with random w_valid gaps of 0–5 cycles, parity 0 → data_out=8'h3C, parity_err=0. busy stays high across the gaps.
- flush after 3 data bits, then frame 8'h01 with parity 1 → exactly one data_valid, data_out=8'h01, parity_err=0.
- PARITY_ODD=1, 8'h01 with parity 0 → parity_err=0. The same frame with parity 1 → parity_err=1.
- 300 consecutive bad frames, back to back → err_cnt=255 and holds. reset mid-frame → all outputs 0, and the next good frame is received correctly.
